// File: rtl/pio_gen2_pkg.sv
// Shared constants for the generation-2 edge-capture PIO: register word
// addresses, bus widths and the debounce counter width.
`timescale 1ns/1ps
package pio_gen2_pkg;

    localparam int ADDR_W    = 3;
    localparam int DATA_W    = 32;
    localparam int DBC_CNT_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_DATA    = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_DIR     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET  = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLR  = 3'd7;

endpackage

// File: rtl/pio_edge_irq_gen2_if.sv
// Avalon-MM slave bus bundle for the PIO: the CPU side is the master,
// the PIO register file is the slave.
`timescale 1ns/1ps
interface pio_edge_irq_gen2_if;
    import pio_gen2_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/pio_in_filter.sv
// One pin of input conditioning: a SYNC_STAGES-deep synchroniser followed by
// an optional stable-count debounce filter (DEBOUNCE = 0 bypasses it).
`timescale 1ns/1ps
module pio_in_filter
    import pio_gen2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic filt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   syncBit;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
        end
    end

    assign syncBit = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            assign filt_o = syncBit;
        end else begin : g_debounce
            localparam logic [DBC_CNT_W-1:0] CNT_LAST = DBC_CNT_W'(DEBOUNCE - 1);

            logic [DBC_CNT_W-1:0] cnt_q, cnt_d;
            logic                 filt_q, filt_d;

            // Any cycle where the synchronised value agrees with the filter
            // restarts the count, so a glitch must be fully re-qualified.
            always_comb begin
                cnt_d  = cnt_q;
                filt_d = filt_q;
                if (syncBit == filt_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    filt_d = syncBit;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                end
            end

            assign filt_o = filt_q;
        end
    endgenerate

endmodule

// File: rtl/pio_edge_irq_gen2.sv
// WIDTH-bit bidirectional PIO with per-bit rising/falling edge capture,
// write-1-to-clear capture register, atomic output set/clear and a level irq.
`timescale 1ns/1ps
module pio_edge_irq_gen2
    import pio_gen2_pkg::*;
#(
    parameter int               WIDTH       = 10,
    parameter int               SYNC_STAGES = 2,
    parameter int               DEBOUNCE    = 0,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_RISE  = '1,
    parameter logic [WIDTH-1:0] RESET_FALL  = '1
) (
    input  logic                clk,
    input  logic                reset,
    pio_edge_irq_gen2_if.slave  bus,
    input  logic [WIDTH-1:0]    in_port,
    output logic [WIDTH-1:0]    out_port,
    output logic [WIDTH-1:0]    out_en,
    output logic                irq
);

    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] rise, fall, ev, w1cMask;
    logic [WIDTH-1:0] readMux;
    logic             unusedWdata;

    logic [WIDTH-1:0] outData_q, outData_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] irqMask_q, irqMask_d;
    logic [WIDTH-1:0] edgeCap_q, edgeCap_d;
    logic [WIDTH-1:0] riseEn_q, riseEn_d;
    logic [WIDTH-1:0] fallEn_q, fallEn_d;
    logic [WIDTH-1:0] filtD_q;
    logic [DATA_W-1:0] readdata_q;

    assign wr          = bus.chipselect & ~bus.write_n;
    assign wdata       = bus.writedata[WIDTH-1:0];
    assign unusedWdata = ^bus.writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        pio_in_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE)
        ) u_filter (
            .clk    (clk),
            .reset  (reset),
            .pin_i  (in_port[i]),
            .filt_o (filt[i])
        );
    end

    assign rise    = filt & ~filtD_q & riseEn_q;
    assign fall    = ~filt & filtD_q & fallEn_q;
    assign ev      = rise | fall;
    assign w1cMask = (wr && bus.address == ADDR_EDGECAP) ? wdata : '0;

    // A fresh edge event overrides a same-cycle W1C so no edge is ever lost.
    always_comb begin
        outData_d = outData_q;
        dir_d     = dir_q;
        irqMask_d = irqMask_q;
        riseEn_d  = riseEn_q;
        fallEn_d  = fallEn_q;
        edgeCap_d = ev | (edgeCap_q & ~w1cMask);
        if (wr) begin
            case (bus.address)
                ADDR_DATA:    outData_d = wdata;
                ADDR_DIR:     dir_d     = wdata;
                ADDR_IRQMASK: irqMask_d = wdata;
                ADDR_RISE_EN: riseEn_d  = wdata;
                ADDR_FALL_EN: fallEn_d  = wdata;
                ADDR_OUTSET:  outData_d = outData_q | wdata;
                ADDR_OUTCLR:  outData_d = outData_q & ~wdata;
                default:      outData_d = outData_q;
            endcase
        end
    end

    always_comb begin
        readMux = '0;
        case (bus.address)
            ADDR_DATA:    readMux = (outData_q & dir_q) | (filt & ~dir_q);
            ADDR_DIR:     readMux = dir_q;
            ADDR_IRQMASK: readMux = irqMask_q;
            ADDR_EDGECAP: readMux = edgeCap_q;
            ADDR_RISE_EN: readMux = riseEn_q;
            ADDR_FALL_EN: readMux = fallEn_q;
            default:      readMux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outData_q  <= RESET_OUT;
            dir_q      <= '0;
            irqMask_q  <= '0;
            edgeCap_q  <= '0;
            riseEn_q   <= RESET_RISE;
            fallEn_q   <= RESET_FALL;
            filtD_q    <= '0;
            readdata_q <= '0;
        end else begin
            outData_q  <= outData_d;
            dir_q      <= dir_d;
            irqMask_q  <= irqMask_d;
            edgeCap_q  <= edgeCap_d;
            riseEn_q   <= riseEn_d;
            fallEn_q   <= fallEn_d;
            filtD_q    <= filt;
            readdata_q <= DATA_W'(readMux);
        end
    end

    assign bus.readdata = readdata_q;
    assign out_port     = outData_q;
    assign out_en       = dir_q;
    assign irq          = |(edgeCap_q & irqMask_q);

endmodule

// File: tb/tb_pio_edge_irq_gen2.sv
// Directed bench for pio_edge_irq_gen2: one instance without debounce and
// one with DEBOUNCE=4 share the same bus and pin stimulus.
`timescale 1ns/1ps
module tb_pio_edge_irq_gen2;
    import pio_gen2_pkg::*;

    localparam int WIDTH = 10;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        int          sel;
    } sbItem_t;

    logic              clk;
    logic              reset;
    logic [2:0]        address;
    logic              chipselect;
    logic              writeN;
    logic [31:0]       writedata;
    logic [WIDTH-1:0]  inPort;
    logic [WIDTH-1:0]  outPort0, outEn0, outPort4, outEn4;
    logic              irq0, irq4;

    int      checks = 0;
    int      errors = 0;
    sbItem_t sbQ[$];

    pio_edge_irq_gen2_if bus0 ();
    pio_edge_irq_gen2_if bus4 ();

    assign bus0.address    = address;
    assign bus0.chipselect = chipselect;
    assign bus0.write_n    = writeN;
    assign bus0.writedata  = writedata;
    assign bus4.address    = address;
    assign bus4.chipselect = chipselect;
    assign bus4.write_n    = writeN;
    assign bus4.writedata  = writedata;

    pio_edge_irq_gen2 #(.WIDTH(WIDTH), .SYNC_STAGES(2), .DEBOUNCE(0)) dut0 (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus0.slave),
        .in_port  (inPort),
        .out_port (outPort0),
        .out_en   (outEn0),
        .irq      (irq0)
    );

    pio_edge_irq_gen2 #(.WIDTH(WIDTH), .SYNC_STAGES(2), .DEBOUNCE(4)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus4.slave),
        .in_port  (inPort),
        .out_port (outPort4),
        .out_en   (outEn4),
        .irq      (irq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        writeN     = 1'b0;
        @(posedge clk);
        #1;
        writeN     = 1'b1;
        chipselect = 1'b0;
    endtask

    // Expected value is queued when the read address is driven and retired
    // once the registered readdata for that address appears.
    task automatic readAndCheck(input int sel, input logic [2:0] addr,
                                input logic [31:0] exp, input string tag);
        sbItem_t     item;
        logic [31:0] obs;
        @(negedge clk);
        address    = addr;
        chipselect = 1'b1;
        writeN     = 1'b1;
        sbQ.push_back('{tag: tag, exp: exp, sel: sel});
        @(posedge clk);
        #1;
        item = sbQ.pop_front();
        obs  = (item.sel == 0) ? bus0.readdata : bus4.readdata;
        checkOutput(item.tag, obs, item.exp);
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset      = 1'b1;
        inPort     = '0;
        chipselect = 1'b0;
        writeN     = 1'b1;
        address    = '0;
        writedata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        inPort     = '0;
        chipselect = 1'b0;
        writeN     = 1'b1;
        address    = '0;
        writedata  = '0;
        applyReset();

        $display("[TB] reset values");
        checkOutput("rst_irq", 32'(irq0), 32'h0);
        checkOutput("rst_out_port", 32'(outPort0), 32'h0);
        checkOutput("rst_out_en", 32'(outEn0), 32'h0);
        readAndCheck(0, ADDR_DATA,    32'h000, "rst_data");
        readAndCheck(0, ADDR_DIR,     32'h000, "rst_dir");
        readAndCheck(0, ADDR_IRQMASK, 32'h000, "rst_irqmask");
        readAndCheck(0, ADDR_EDGECAP, 32'h000, "rst_edgecap");
        readAndCheck(0, ADDR_RISE_EN, 32'h3FF, "rst_rise_en");
        readAndCheck(0, ADDR_FALL_EN, 32'h3FF, "rst_fall_en");
        readAndCheck(0, ADDR_OUTSET,  32'h000, "rst_outset");
        readAndCheck(0, ADDR_OUTCLR,  32'h000, "rst_outclr");

        $display("[TB] rising edge latency and irq");
        applyStimulus(ADDR_IRQMASK, 32'h008);
        @(negedge clk);
        inPort[3] = 1'b1;
        @(posedge clk); #1;
        checkOutput("lat_irq_e1", 32'(irq0), 32'h0);
        @(posedge clk); #1;
        checkOutput("lat_irq_e2", 32'(irq0), 32'h0);
        @(posedge clk); #1;
        checkOutput("lat_irq_e3", 32'(irq0), 32'h1);
        readAndCheck(0, ADDR_EDGECAP, 32'h008, "lat_edgecap");
        applyStimulus(ADDR_EDGECAP, 32'h008);
        checkOutput("w1c_irq_low", 32'(irq0), 32'h0);

        $display("[TB] falling edges disabled");
        applyStimulus(ADDR_FALL_EN, 32'h000);
        readAndCheck(0, ADDR_FALL_EN, 32'h000, "fall_en_rd");
        @(negedge clk);
        inPort[5] = 1'b1;
        repeat (4) @(posedge clk);
        applyStimulus(ADDR_EDGECAP, 32'h3FF);
        readAndCheck(0, ADDR_EDGECAP, 32'h000, "fall_pre");
        @(negedge clk);
        inPort[5] = 1'b0;
        repeat (4) @(posedge clk);
        readAndCheck(0, ADDR_EDGECAP, 32'h000, "fall_ignored");
        @(negedge clk);
        inPort[5] = 1'b1;
        repeat (4) @(posedge clk);
        readAndCheck(0, ADDR_EDGECAP, 32'h020, "fall_rise_only");

        $display("[TB] debounce filter");
        applyReset();
        @(negedge clk);
        inPort[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        inPort[0] = 1'b0;
        repeat (10) @(posedge clk);
        readAndCheck(4, ADDR_EDGECAP, 32'h000, "dbc_glitch");
        readAndCheck(0, ADDR_EDGECAP, 32'h001, "nodbc_glitch");
        @(negedge clk);
        inPort[0] = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        inPort[0] = 1'b0;
        @(posedge clk);
        readAndCheck(4, ADDR_EDGECAP, 32'h001, "dbc_rise");
        applyStimulus(ADDR_EDGECAP, 32'h001);
        readAndCheck(4, ADDR_EDGECAP, 32'h000, "dbc_cleared");
        repeat (6) @(posedge clk);
        readAndCheck(4, ADDR_EDGECAP, 32'h001, "dbc_fall");

        $display("[TB] event beats same-cycle clear");
        applyStimulus(ADDR_EDGECAP, 32'h3FF);
        @(negedge clk);
        inPort[1] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        inPort[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        applyStimulus(ADDR_EDGECAP, 32'h001);
        readAndCheck(0, ADDR_EDGECAP, 32'h003, "ev_wins_w1c");
        applyStimulus(ADDR_EDGECAP, 32'h002);
        readAndCheck(0, ADDR_EDGECAP, 32'h001, "w1c_selective");

        $display("[TB] output set/clear and data readback");
        @(negedge clk);
        inPort = 10'h2A3;
        repeat (4) @(posedge clk);
        applyStimulus(ADDR_DIR, 32'h00F);
        applyStimulus(ADDR_DATA, 32'h005);
        applyStimulus(ADDR_OUTSET, 32'h00A);
        checkOutput("outset_port", 32'(outPort0), 32'h00F);
        applyStimulus(ADDR_OUTCLR, 32'h001);
        checkOutput("outclr_port", 32'(outPort0), 32'h00E);
        checkOutput("out_en", 32'(outEn0), 32'h00F);
        readAndCheck(0, ADDR_DATA,   32'h2AE, "data_mix");
        readAndCheck(0, ADDR_DIR,    32'h00F, "dir_kept");
        readAndCheck(0, ADDR_OUTSET, 32'h000, "outset_rd0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
